inst_fetch: RTL
===============

# inst_fetch

Instruction fetch unit producing the 32-bit instruction word consumed by the main decoder's `comb_decode_inst` input. Maintains the fetch PC, issues in-order word reads to instruction memory over a valid/ready request channel, buffers returned words with their PCs in a small FIFO, and presents them to decode under a valid/ready handshake. Supports a one-cycle redirect from execute (branch/jump) that flushes buffered and in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, FIFO entries and maximum outstanding requests (power of two, ≥2)

- `clk`  in  1  system clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `imem_req_valid`  out  1  read request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_resp_valid`  in  1  read data valid (in order, no backpressure)
- `imem_resp_data`  in  32  read data
- `redirect_valid`  in  1  redirect strobe from execute
- `redirect_pc`  in  32  redirect target
- `inst_valid`  out  1  instruction available to decode
- `inst_ready`  in  1  decode accepts instruction
- `inst_out`  out  32  instruction word to decoder
- `inst_pc`  out  32  PC of `inst_out`
- `fetch_misaligned`  out  1  misaligned redirect flag (see Configuration)

## Operation
- States: WAIT (one cycle after reset release, no requests), RUN, FLUSH, HALT.
- WAIT -> RUN unconditionally.
- RUN: `imem_req_valid` = 1 when `outstanding + fifo_count < DEPTH`; `imem_req_addr` = `fetch_pc`; on request handshake `fetch_pc += 4`, `outstanding++`.
- Each response in RUN: `outstanding--`, push `{resp_pc, imem_resp_data}`, `resp_pc += 4`. Slot is pre-reserved, so a response never finds the FIFO full.
- Response with `outstanding == 0`: protocol error, ignored, no state change.
- Redirect (highest priority, any state except WAIT): `fetch_pc` and `resp_pc` <- target, FIFO cleared, `drop` <- in-flight count (including a request handshaking this same cycle). Next state FLUSH if `drop > 0`, else RUN.
- FLUSH: no requests; each response discarded, `drop--`; when `drop` reaches 0 -> RUN. Redirect in FLUSH reloads PCs, `drop` unchanged.
- Output: `inst_valid` = FIFO non-empty; pop on `inst_valid && inst_ready`. Push and pop in the same cycle allowed at any occupancy.
- A pop in the redirect cycle completes normally; the FIFO is empty on the next cycle regardless.
- FIFO empty: `inst_out` = 32'h0000_0013 (NOP), `inst_pc` holds its last value.
- Arithmetic: PCs are 32-bit, wrap from 32'hFFFF_FFFC to 0 silently; counters are $clog2(DEPTH)+1 bits wide.

## Timing
- Reset values: `imem_req_valid` 0, `imem_req_addr` = `RESET_PC`, `inst_valid` 0, `inst_out` 32'h0000_0013, `inst_pc` 0, `fetch_misaligned` 0, state WAIT.
- First `imem_req_valid` asserts in the second cycle after `rstn` deasserts.
- Request accepted at cycle t, response at t+k (k≥1): `inst_valid` asserts at t+k+1 (registered FIFO output).
- Redirect at cycle r: `inst_valid` 0 at r+1; first request to the target at r+1 if no fetches were in flight.
- Sustained throughput: one instruction per cycle when k=1 and `DEPTH` ≥ 2.
- Reset mid-operation: all state returns immediately to the reset values; late responses after reset release with `outstanding == 0` are ignored.

## Configuration
- `INST_FETCH_MISALIGN_TRAP_EN` defined: a redirect with `redirect_pc[1:0] != 0` flushes as normal, then enters HALT. In HALT there are no requests and `fetch_misaligned` = 1. An aligned redirect resumes through FLUSH/RUN, and `fetch_misaligned` deasserts the cycle after.
- Not defined: `redirect_pc[1:0]` forced to 0, HALT is unreachable, and `fetch_misaligned` is tied 0.

## Test plan
- Reset with `RESET_PC`=32'h100, memory latency 1, `inst_ready`=1 -> requests 0x100, 0x104, 0x108…; `inst_pc` 0x100 paired with `imem_resp_data` of that address, one instruction per cycle.
- `inst_ready`=0 for 10 cycles -> exactly `DEPTH` requests issued, then `imem_req_valid`=0; on release, instructions resume in order with none lost.
- Redirect to 32'h200 with 2 requests in flight (latency 3) -> both responses dropped, FLUSH then RUN, first valid `inst_pc` = 0x200.
- Redirect in the same cycle as a request handshake -> that request's response is dropped; `drop` = 2 when one other fetch was in flight.
- `fetch_pc` at 32'hFFFF_FFFC -> next request address 32'h0000_0000.
- With macro: redirect to 32'h202 -> HALT, `fetch_misaligned`=1, no requests; then redirect to 32'h300 -> flag clears and fetching resumes at 0x300.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: fetch PC, in-order imem reads, small instruction FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining INST_FETCH_MISALIGN_TRAP_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_misaligned
);

    // state  | meaning
    // S_WAIT | first cycle after reset release, no requests
    // S_RUN  | issue requests, buffer responses
    // S_FLUSH| discard responses of fetches issued before a redirect
    // S_HALT | parked after a misaligned redirect, no requests
    typedef enum logic [1:0] {S_WAIT, S_RUN, S_FLUSH, S_HALT} state_t;

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [31:0]     resp_pc;
    logic [31:0]     last_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     mem_data [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];
    logic            halt_pend;

    logic            pop, push, req_hs, resp_ok, resp_drop, redirect, mis;
    logic [CW-1:0]   req_inc, resp_dec, pop_dec, push_inc, inflight;
    logic [CW:0]     used;
    logic [31:0]     target;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign redirect  = redirect_valid && (state != S_WAIT);
    assign pop       = (count != '0) && inst_ready;
    assign resp_ok   = imem_resp_valid && (state == S_RUN) && (outstanding != '0);
    assign resp_drop = imem_resp_valid && (state == S_FLUSH) && (drop != '0);
    assign push      = resp_ok && !redirect;

    assign req_inc   = {{(CW-1){1'b0}}, req_hs};
    assign resp_dec  = {{(CW-1){1'b0}}, resp_ok | resp_drop};
    assign pop_dec   = {{(CW-1){1'b0}}, pop};
    assign push_inc  = {{(CW-1){1'b0}}, push};

    // A slot freed by this cycle's pop is credited immediately so k=1 sustains one word per cycle.
    assign used           = {1'b0, outstanding} + {1'b0, count} - {1'b0, pop_dec};
    assign imem_req_valid = (state == S_RUN) && (used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // Only one of outstanding/drop is non-zero in any state.
    assign inflight = outstanding + drop + req_inc - resp_dec;

`ifdef INST_FETCH_MISALIGN_TRAP_EN
    assign mis              = (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = (state == S_HALT);
`else
    assign mis              = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_WAIT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            halt_pend   <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= '0;
            drop        <= inflight;
            halt_pend   <= mis;
            if (inflight != '0) state <= S_FLUSH;
            else                state <= mis ? S_HALT : S_RUN;
        end else begin
            case (state)
                S_WAIT: state <= S_RUN;
                S_RUN: begin
                    if (req_hs)  fetch_pc <= fetch_pc + 32'd4;
                    if (resp_ok) resp_pc  <= resp_pc + 32'd4;
                    outstanding <= outstanding + req_inc - resp_dec;
                end
                S_FLUSH: begin
                    if (resp_drop) begin
                        drop <= drop - CW'(1);
                        if (drop == CW'(1)) state <= halt_pend ? S_HALT : S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_pc <= '0;
        end else begin
            last_pc <= inst_pc;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + push_inc - pop_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_resp_data;
            mem_pc[wr_ptr]   <= resp_pc;
        end
    end

    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? mem_data[rd_ptr] : NOP;
    assign inst_pc    = inst_valid ? mem_pc[rd_ptr] : last_pc;

endmodule
